rename_rob_param: RTL and testbench

RENAME_ROB_PARAM -- requirements
Module: rename_rob_param

---
 rtl/rename_rob_param.sv | 221 ++++++++++++++++++++++
 tb/tb_rename_rob_param.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_rob_param.sv
// Reorder buffer: allocates rename tags, captures CDB results, bypasses operands, commits in order.
// Latency: dispatch tag is combinational; commit at the earliest one cycle after the CDB write.
// Backpressure: disp_ready drops when full or flushing; a store holds the head until st_resp.
module rename_rob_param #(
   parameter  int DEPTH   = 8,
   parameter  int NUM_CDB = 3,
   localparam int TAG_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     disp_valid,
   output logic                     disp_ready,
   input  logic [1:0]               disp_type,
   input  logic [4:0]               disp_rd,
   output logic [TAG_W-1:0]         disp_tag,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   input  logic [NUM_CDB*32-1:0]    cdb_val,
   input  logic [NUM_CDB*32-1:0]    cdb_addr,
   input  logic [NUM_CDB-1:0]       cdb_mispred,
   input  logic [NUM_CDB*32-1:0]    cdb_target,
   input  logic [TAG_W-1:0]         rd_tag_a,
   input  logic [TAG_W-1:0]         rd_tag_b,
   output logic                     rd_ready_a,
   output logic                     rd_ready_b,
   output logic [31:0]              rd_val_a,
   output logic [31:0]              rd_val_b,
   output logic                     rf_we,
   output logic [4:0]               rf_rd,
   output logic [TAG_W-1:0]         rf_tag,
   output logic [31:0]              rf_val,
   output logic                     st_req,
   output logic [31:0]              st_addr,
   output logic [31:0]              st_wdata,
   input  logic                     st_resp,
   output logic                     flush,
   output logic [31:0]              flush_pc,
   output logic [TAG_W:0]           count
);

   localparam logic [1:0]     TYPE_REG = 2'd0;
   localparam logic [1:0]     TYPE_ST  = 2'd1;
   localparam logic [1:0]     TYPE_BR  = 2'd2;
   localparam logic [0:0]     ST_IDLE  = 1'b0;
   localparam logic [0:0]     ST_WAIT  = 1'b1;
   localparam logic [TAG_W:0] DEPTH_V  = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, mispred_q, mispred_d;
   logic [1:0]       type_q   [DEPTH];
   logic [1:0]       type_d   [DEPTH];
   logic [4:0]       rd_q     [DEPTH];
   logic [4:0]       rd_d     [DEPTH];
   logic [31:0]      val_q    [DEPTH];
   logic [31:0]      val_d    [DEPTH];
   logic [31:0]      addr_q   [DEPTH];
   logic [31:0]      addr_d   [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [31:0]      target_d [DEPTH];
   logic [TAG_W:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [0:0]       st_q, st_d;

   logic [TAG_W-1:0] head_idx, tail_idx;
   logic             head_rdy, commit, disp_fire;
   logic             rf_we_c, st_req_c, flush_c;
   logic             hit_a, hit_b;
   logic [31:0]      byp_a, byp_b;

   assign head_idx = head_q[TAG_W-1:0];
   assign tail_idx = tail_q[TAG_W-1:0];
   assign head_rdy = busy_q[head_idx] && ready_q[head_idx];

   // Head decode: decides what the completed head entry does this cycle and steps the store FSM.
   always_comb begin
      commit   = 1'b0;
      rf_we_c  = 1'b0;
      st_req_c = 1'b0;
      flush_c  = 1'b0;
      st_d     = st_q;
      if (head_rdy) begin
         case (type_q[head_idx])
            TYPE_REG: begin
               rf_we_c = 1'b1;
               commit  = 1'b1;
            end
            TYPE_ST: begin
               st_req_c = 1'b1;
               if (st_resp) begin
                  commit = 1'b1;
                  st_d   = ST_IDLE;
               end else begin
                  st_d   = ST_WAIT;
               end
            end
            TYPE_BR: begin
               if (mispred_q[head_idx]) flush_c = 1'b1;
               else                     commit  = 1'b1;
            end
            default: commit = 1'b1;
         endcase
      end
   end

   // Flush and a full buffer both refuse dispatch; only the registered count is consulted.
   assign disp_ready = rst && (count_q < DEPTH_V) && !flush_c;
   assign disp_fire  = disp_valid && disp_ready;
   assign disp_tag   = tail_idx;
   assign count      = count_q;

   assign rf_we    = rf_we_c;
   assign rf_rd    = rf_we_c  ? rd_q[head_idx]     : 5'd0;
   assign rf_tag   = rf_we_c  ? head_idx           : '0;
   assign rf_val   = rf_we_c  ? val_q[head_idx]    : 32'd0;
   assign st_req   = st_req_c;
   assign st_addr  = st_req_c ? addr_q[head_idx]   : 32'd0;
   assign st_wdata = st_req_c ? val_q[head_idx]    : 32'd0;
   assign flush    = flush_c;
   assign flush_pc = flush_c  ? target_q[head_idx] : 32'd0;

   // Operand bypass: the highest-index CDB port carrying the tag overrides the stored value.
   always_comb begin
      hit_a = 1'b0;
      hit_b = 1'b0;
      byp_a = 32'd0;
      byp_b = 32'd0;
      for (int p = 0; p < NUM_CDB; p++) begin
         if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == rd_tag_a) begin
            hit_a = 1'b1;
            byp_a = cdb_val[p*32 +: 32];
         end
         if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == rd_tag_b) begin
            hit_b = 1'b1;
            byp_b = cdb_val[p*32 +: 32];
         end
      end
   end

   assign rd_ready_a = busy_q[rd_tag_a] && (ready_q[rd_tag_a] || hit_a);
   assign rd_ready_b = busy_q[rd_tag_b] && (ready_q[rd_tag_b] || hit_b);
   assign rd_val_a   = !rst ? 32'd0 : (hit_a ? byp_a : val_q[rd_tag_a]);
   assign rd_val_b   = !rst ? 32'd0 : (hit_b ? byp_b : val_q[rd_tag_b]);

   // Next state: CDB capture, then commit release, then dispatch allocate; flush overrides all.
   always_comb begin
      busy_d    = busy_q;
      ready_d   = ready_q;
      mispred_d = mispred_q;
      type_d    = type_q;
      rd_d      = rd_q;
      val_d     = val_q;
      addr_d    = addr_q;
      target_d  = target_q;
      head_d    = head_q;
      tail_d    = tail_q;
      // A store waiting on st_resp must keep its address and data stable, so it ignores the CDB.
      for (int e = 0; e < DEPTH; e++) begin
         for (int p = 0; p < NUM_CDB; p++) begin
            if (cdb_valid[p] && cdb_tag[p*TAG_W +: TAG_W] == TAG_W'(e) && busy_q[e] &&
                !(st_q == ST_WAIT && head_idx == TAG_W'(e))) begin
               ready_d[e]   = 1'b1;
               val_d[e]     = cdb_val[p*32 +: 32];
               addr_d[e]    = cdb_addr[p*32 +: 32];
               mispred_d[e] = cdb_mispred[p];
               target_d[e]  = cdb_target[p*32 +: 32];
            end
         end
      end
      if (commit) begin
         busy_d[head_idx]  = 1'b0;
         ready_d[head_idx] = 1'b0;
         head_d            = head_q + 1'b1;
      end
      if (disp_fire) begin
         busy_d[tail_idx]    = 1'b1;
         ready_d[tail_idx]   = 1'b0;
         mispred_d[tail_idx] = 1'b0;
         type_d[tail_idx]    = disp_type;
         rd_d[tail_idx]      = disp_rd;
         tail_d              = tail_q + 1'b1;
      end
      count_d = count_q + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(commit);
      if (flush_c) begin
         busy_d    = '0;
         ready_d   = '0;
         mispred_d = '0;
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
      end
   end

   // Control state registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q    <= '0;
         ready_q   <= '0;
         mispred_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         st_q      <= ST_IDLE;
      end else begin
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         mispred_q <= mispred_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         st_q      <= st_d;
      end
   end

   // Entry payload needs no reset: every field is written before its busy bit exposes it.
   always_ff @(posedge clk) begin
      type_q   <= type_d;
      rd_q     <= rd_d;
      val_q    <= val_d;
      addr_q   <= addr_d;
      target_q <= target_d;
   end

endmodule

// File: tb/tb_rename_rob_param.sv
// Scoreboard bench for rename_rob_param: stimulus pushes expected commit events, a monitor pops them.
// Latency: expectations are ordered; the monitor matches whenever rf_we, flush or a store handshake appears.
// Backpressure: dispatch refusal and store wait states are checked inline by the stimulus.
module tb_rename_rob_param;

   localparam int DEPTH   = 8;
   localparam int NUM_CDB = 3;
   localparam int TAG_W   = 3;
   localparam int K_REG   = 0;
   localparam int K_ST    = 1;
   localparam int K_FLUSH = 2;

   logic                     clk;
   logic                     rst;
   logic                     disp_valid;
   logic                     disp_ready;
   logic [1:0]               disp_type;
   logic [4:0]               disp_rd;
   logic [TAG_W-1:0]         disp_tag;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*TAG_W-1:0] cdb_tag;
   logic [NUM_CDB*32-1:0]    cdb_val;
   logic [NUM_CDB*32-1:0]    cdb_addr;
   logic [NUM_CDB-1:0]       cdb_mispred;
   logic [NUM_CDB*32-1:0]    cdb_target;
   logic [TAG_W-1:0]         rd_tag_a, rd_tag_b;
   logic                     rd_ready_a, rd_ready_b;
   logic [31:0]              rd_val_a, rd_val_b;
   logic                     rf_we;
   logic [4:0]               rf_rd;
   logic [TAG_W-1:0]         rf_tag;
   logic [31:0]              rf_val;
   logic                     st_req;
   logic [31:0]              st_addr, st_wdata;
   logic                     st_resp;
   logic                     flush;
   logic [31:0]              flush_pc;
   logic [TAG_W:0]           count;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] tag;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   rename_rob_param #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_type(disp_type),
      .disp_rd(disp_rd), .disp_tag(disp_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_addr(cdb_addr),
      .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
      .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b), .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
      .rd_val_a(rd_val_a), .rd_val_b(rd_val_b),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_tag(rf_tag), .rf_val(rf_val),
      .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_resp(st_resp),
      .flush(flush), .flush_pc(flush_pc), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b, input logic [31:0] tag);
      exp_t e;
      e.kind = kind; e.a = a; e.b = b; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [1:0] ty, input logic [4:0] rd, input int exp_tag);
      disp_valid = 1'b1;
      disp_type  = ty;
      disp_rd    = rd;
      @(negedge clk);
      chk("disp_ready", {31'd0, disp_ready}, 32'd1);
      chk("disp_tag", {29'd0, disp_tag}, exp_tag);
      step();
      disp_valid = 1'b0;
   endtask

   task automatic cdb_set(input int p, input int tag, input logic [31:0] val, input logic [31:0] addr,
                          input logic mp, input logic [31:0] tgt);
      cdb_valid[p]             = 1'b1;
      cdb_tag[p*TAG_W +: TAG_W] = TAG_W'(tag);
      cdb_val[p*32 +: 32]      = val;
      cdb_addr[p*32 +: 32]     = addr;
      cdb_mispred[p]           = mp;
      cdb_target[p*32 +: 32]   = tgt;
   endtask

   task automatic cdb_clr();
      cdb_valid   = '0;
      cdb_tag     = '0;
      cdb_val     = '0;
      cdb_addr    = '0;
      cdb_mispred = '0;
      cdb_target  = '0;
   endtask

   // Monitor: every commit-side event the DUT presents must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rf_we) begin
         if (sb.size() == 0) chk("unexpected_rf_we", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("reg_kind", K_REG, e.kind);
            chk("rf_rd", {27'd0, rf_rd}, e.a);
            chk("rf_val", rf_val, e.b);
            chk("rf_tag", {29'd0, rf_tag}, e.tag);
         end
      end
      if (flush) begin
         if (sb.size() == 0) chk("unexpected_flush", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("flush_kind", K_FLUSH, e.kind);
            chk("flush_pc", flush_pc, e.a);
         end
      end
      if (st_req && st_resp) begin
         if (sb.size() == 0) chk("unexpected_store", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("st_kind", K_ST, e.kind);
            chk("st_addr", st_addr, e.a);
            chk("st_wdata", st_wdata, e.b);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b0; disp_valid = 1'b0; disp_type = 2'd0; disp_rd = 5'd0;
      rd_tag_a = '0; rd_tag_b = '0; st_resp = 1'b0;
      cdb_clr();
      repeat (2) @(negedge clk);
      chk("rst_disp_ready", {31'd0, disp_ready}, 32'd0);
      chk("rst_count", {28'd0, count}, 32'd0);
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_st_req", {31'd0, st_req}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("release_disp_ready", {31'd0, disp_ready}, 32'd1);
      step();

      // Fill: REG rd=1..8 land on tags 0..7, then a ninth dispatch is refused.
      for (int i = 0; i < 8; i++) disp(2'd0, 5'(i + 1), i);
      disp_valid = 1'b1; disp_rd = 5'd9;
      @(negedge clk);
      chk("full_disp_ready", {31'd0, disp_ready}, 32'd0);
      chk("full_count", {28'd0, count}, 32'd8);
      step();
      disp_valid = 1'b0;

      // Bypass with a same-tag collision: port1 beats port0.
      rd_tag_a = 3'd3; rd_tag_b = 3'd4;
      cdb_set(0, 3, 32'h01, 32'h0, 1'b0, 32'h0);
      cdb_set(1, 3, 32'hAB, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      chk("byp_ready_a", {31'd0, rd_ready_a}, 32'd1);
      chk("byp_val_a", rd_val_a, 32'hAB);
      chk("byp_ready_b", {31'd0, rd_ready_b}, 32'd0);
      step();
      cdb_clr();
      @(negedge clk);
      chk("stored_ready_a", {31'd0, rd_ready_a}, 32'd1);
      chk("stored_val_a", rd_val_a, 32'hAB);

      // Out-of-order completion, in-order commit on consecutive cycles.
      push(K_REG, 1, 32'h10, 0);
      push(K_REG, 2, 32'h11, 1);
      push(K_REG, 3, 32'h22, 2);
      push(K_REG, 4, 32'hAB, 3);
      step();
      cdb_set(0, 2, 32'h22, 32'h0, 1'b0, 32'h0);
      step();
      cdb_clr();
      cdb_set(0, 0, 32'h10, 32'h0, 1'b0, 32'h0);
      cdb_set(1, 1, 32'h11, 32'h0, 1'b0, 32'h0);
      step();
      cdb_clr();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ooo_rf_we_run", {31'd0, rf_we}, 32'd1);
         step();
      end
      @(negedge clk);
      chk("ooo_rf_we_stop", {31'd0, rf_we}, 32'd0);
      chk("ooo_count", {28'd0, count}, 32'd4);

      // Drain tags 4..7 so the pointers wrap to index 0.
      push(K_REG, 5, 32'h44, 4);
      push(K_REG, 6, 32'h55, 5);
      push(K_REG, 7, 32'h66, 6);
      push(K_REG, 8, 32'h77, 7);
      step();
      cdb_set(0, 4, 32'h44, 32'h0, 1'b0, 32'h0);
      cdb_set(1, 5, 32'h55, 32'h0, 1'b0, 32'h0);
      cdb_set(2, 6, 32'h66, 32'h0, 1'b0, 32'h0);
      step();
      cdb_clr();
      cdb_set(0, 7, 32'h77, 32'h0, 1'b0, 32'h0);
      step();
      cdb_clr();
      repeat (4) step();
      @(negedge clk);
      chk("drain_count", {28'd0, count}, 32'd0);
      step();

      // Mispredict: BR at tag1 with tags 2..5 busy.
      disp(2'd0, 5'd9, 0);
      disp(2'd2, 5'd0, 1);
      for (int i = 0; i < 4; i++) disp(2'd0, 5'(10 + i), 2 + i);
      push(K_REG, 9, 32'h55, 0);
      push(K_FLUSH, 32'h4000, 32'h0, 0);
      cdb_set(0, 0, 32'h55, 32'h0, 1'b0, 32'h0);
      step();
      cdb_clr();
      cdb_set(0, 1, 32'h0, 32'h0, 1'b1, 32'h4000);
      cdb_set(1, 3, 32'h33, 32'h0, 1'b0, 32'h0);
      step();
      cdb_clr();
      disp_valid = 1'b1; disp_type = 2'd0; disp_rd = 5'd20;
      @(negedge clk);
      chk("flush_high", {31'd0, flush}, 32'd1);
      chk("flush_disp_ready", {31'd0, disp_ready}, 32'd0);
      chk("flush_pre_count", {28'd0, count}, 32'd5);
      chk("flush_pre_ready3", {31'd0, rd_ready_a}, 32'd1);
      step();
      disp_valid = 1'b0;
      @(negedge clk);
      chk("flush_one_cycle", {31'd0, flush}, 32'd0);
      chk("flush_count", {28'd0, count}, 32'd0);
      chk("flush_cleared3", {31'd0, rd_ready_a}, 32'd0);

      // Store at tag0 with three wait cycles; st_resp before the store is ready is ignored.
      step();
      st_resp = 1'b1;
      disp(2'd1, 5'd0, 0);
      st_resp = 1'b0;
      push(K_ST, 32'h100, 32'hDEAD, 0);
      cdb_set(2, 0, 32'hDEAD, 32'h100, 1'b0, 32'h0);
      step();
      cdb_clr();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) st_resp = 1'b1;
         @(negedge clk);
         chk("st_req_hold", {31'd0, st_req}, 32'd1);
         chk("st_addr_hold", st_addr, 32'h100);
         chk("st_wdata_hold", st_wdata, 32'hDEAD);
         step();
      end
      st_resp = 1'b0;
      @(negedge clk);
      chk("st_req_done", {31'd0, st_req}, 32'd0);
      chk("st_count", {28'd0, count}, 32'd0);
      step();

      // Zero-wait store at tag1.
      disp(2'd1, 5'd0, 1);
      push(K_ST, 32'h200, 32'hBEEF, 1);
      cdb_set(0, 1, 32'hBEEF, 32'h200, 1'b0, 32'h0);
      step();
      cdb_clr();
      st_resp = 1'b1;
      @(negedge clk);
      chk("zw_st_req", {31'd0, st_req}, 32'd1);
      step();
      st_resp = 1'b0;
      @(negedge clk);
      chk("zw_st_req_done", {31'd0, st_req}, 32'd0);
      chk("zw_count", {28'd0, count}, 32'd0);
      step();

      // Twelve pipelined dispatch/commit pairs wrapping through tag 7 -> 0.
      for (int k = 0; k < 14; k++) begin
         disp_valid = (k < 12);
         disp_type  = 2'd0;
         disp_rd    = 5'(k);
         if (k < 12) push(K_REG, k, 32'h100 + k, (2 + k) % 8);
         cdb_clr();
         if (k >= 1 && k <= 12) cdb_set(0, (2 + k - 1) % 8, 32'h100 + k - 1, 32'h0, 1'b0, 32'h0);
         @(negedge clk);
         if (k < 12) chk("wrap_disp_tag", {29'd0, disp_tag}, (2 + k) % 8);
         chk("wrap_count", {28'd0, count}, (k == 0) ? 0 : (k == 1) ? 1 : (k <= 12) ? 2 : 1);
         step();
      end
      disp_valid = 1'b0;
      cdb_clr();
      @(negedge clk);
      chk("wrap_end_count", {28'd0, count}, 32'd0);
      step();

      // Reset in the middle of a store wait.
      disp(2'd1, 5'd0, 6);
      cdb_set(0, 6, 32'h1234, 32'h300, 1'b0, 32'h0);
      step();
      cdb_clr();
      @(negedge clk);
      chk("rst_st_first", {31'd0, st_req}, 32'd1);
      step();
      @(negedge clk);
      chk("rst_st_wait", {31'd0, st_req}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_st_req", {31'd0, st_req}, 32'd0);
      chk("async_st_addr", st_addr, 32'd0);
      chk("async_count", {28'd0, count}, 32'd0);
      chk("async_disp_ready", {31'd0, disp_ready}, 32'd0);
      step();
      step();
      rst = 1'b1;
      disp(2'd0, 5'd1, 0);
      @(negedge clk);
      chk("post_rst_count", {28'd0, count}, 32'd1);
      chk("sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
